// File: rtl/dice_race_pkg.sv
// Shared types and constants for the dice race game controller.
package dice_race_pkg;

  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned POS_W       = 5;

  // Turn FSM states; encodings are visible on state_out.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitRoll  = 3'd1,
    StMove      = 3'd2,
    StWaitClear = 3'd3,
    StNext      = 3'd4,
    StWin       = 3'd5
  } state_e;

  // Color codes produced by the color-detection front end.
  typedef enum logic [1:0] {
    ColorNone  = 2'd0,
    ColorRed   = 2'd1,
    ColorGreen = 2'd2,
    ColorBlue  = 2'd3
  } color_e;

  // Advance a player index, wrapping at the number of active players.
  function automatic logic [1:0] next_player(input logic [1:0] cur, input int unsigned num);
    if ({30'd0, cur} + 32'd1 >= num) begin
      return 2'd0;
    end
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Down-counting step timer: load reloads to PERIOD-1, enable counts down,
// tick fires on the cycle the count sits at zero and the counter reloads.
module step_timer #(
  parameter int unsigned PERIOD = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned     CntW   = $clog2(PERIOD);
  localparam logic [CntW-1:0] Reload = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && !load_i && !clear_i && (cnt_q == '0);

  // Next count: clear beats load beats the free-running countdown.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = Reload;
    end else if (enable_i) begin
      cnt_d = (cnt_q == '0) ? Reload : cnt_q - CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_turn_controller.sv
// Turn sequencing for the dice race board: waits for a die result, walks the
// current player forward one square per step period, detects the goal and
// rotates turns. Define TURN_TIMEOUT_EN to skip a turn when no roll arrives
// within TIMEOUT_CYCLES.
module game_turn_controller
  import dice_race_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned TRACK_LEN      = 20,
  parameter int unsigned STEP_PERIOD    = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        game_enable,
  input  logic        result_ready,
  input  logic [1:0]  movement_steps,
  input  logic        turn_end,
  output logic [1:0]  current_player,
  output logic [19:0] player_pos,
  output logic        step_pulse,
  output logic [2:0]  state_out,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        turn_skipped
);

  if (NUM_PLAYERS < 2 || NUM_PLAYERS > MAX_PLAYERS || TRACK_LEN < 4 || TRACK_LEN > 32 ||
      STEP_PERIOD < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("game_turn_controller: parameter out of range");
  end

  localparam logic [POS_W-1:0] Goal = POS_W'(TRACK_LEN - 1);

  state_e                             state_q, state_d;
  logic [1:0]                         player_q, player_d;
  logic [MAX_PLAYERS-1:0][POS_W-1:0]  pos_q, pos_d;
  logic [1:0]                         steps_q, steps_d;
  logic                               step_pulse_q, step_pulse_d;

  logic             timer_clear, timer_load, timer_en, tick;
  logic             accept;
  logic             timeout_hit;
  logic [POS_W-1:0] new_pos;

  assign accept  = (state_q == StWaitRoll) && result_ready && (movement_steps != 2'd0);
  assign new_pos = pos_q[player_q] + POS_W'(1);

  step_timer #(
    .PERIOD (STEP_PERIOD)
  ) u_step_timer (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (timer_clear),
    .load_i   (timer_load),
    .enable_i (timer_en),
    .tick_o   (tick)
  );

  // Next-state logic; dropping game_enable overrides every other event.
  always_comb begin
    state_d      = state_q;
    player_d     = player_q;
    pos_d        = pos_q;
    steps_d      = steps_q;
    step_pulse_d = 1'b0;
    timer_clear  = 1'b0;
    timer_load   = 1'b0;
    timer_en     = game_enable && (state_q == StMove);
    if (!game_enable) begin
      state_d     = StIdle;
      player_d    = 2'd0;
      pos_d       = '0;
      steps_d     = 2'd0;
      timer_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StWaitRoll;
          player_d = 2'd0;
          pos_d    = '0;
          steps_d  = 2'd0;
        end
        StWaitRoll: begin
          if (accept) begin
            steps_d    = movement_steps;
            timer_load = 1'b1;
            state_d    = StMove;
          end else if (timeout_hit) begin
            state_d = StNext;
          end
        end
        StMove: begin
          if (tick) begin
            step_pulse_d     = 1'b1;
            pos_d[player_q]  = new_pos;
            steps_d          = steps_q - 2'd1;
            if (new_pos == Goal) begin
              // Leftover steps are discarded once the goal is reached.
              steps_d = 2'd0;
              state_d = StWin;
            end else if (steps_q == 2'd1) begin
              state_d = StWaitClear;
            end
          end
        end
        StWaitClear: begin
          if (turn_end) begin
            state_d = StNext;
          end
        end
        StNext: begin
          player_d = next_player(player_q, NUM_PLAYERS);
          state_d  = StWaitRoll;
        end
        StWin: begin
          state_d = StWin;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM, position and registered step_pulse state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      player_q     <= 2'd0;
      pos_q        <= '0;
      steps_q      <= 2'd0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      player_q     <= player_d;
      pos_q        <= pos_d;
      steps_q      <= steps_d;
      step_pulse_q <= step_pulse_d;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           skip_q, skip_d;

  // Cycles spent in WAIT_ROLL; any other state holds the count at zero.
  always_comb begin
    to_cnt_d = '0;
    if (game_enable && (state_q == StWaitRoll)) begin
      to_cnt_d = to_cnt_q + ToW'(1);
    end
  end

  assign timeout_hit = (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));
  assign skip_d      = game_enable && (state_q == StWaitRoll) && !accept && timeout_hit;

  // Timeout counter and registered skip pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      skip_q   <= skip_d;
    end
  end

  assign turn_skipped = skip_q;
`else
  assign timeout_hit  = 1'b0;
  assign turn_skipped = 1'b0;
`endif

  assign current_player = player_q;
  assign player_pos     = pos_q;
  assign step_pulse     = step_pulse_q;
  assign state_out      = state_q;
  assign game_over      = (state_q == StWin);
  assign winner         = (state_q == StWin) ? player_q : 2'd0;

endmodule

// File: tb/tb_game_turn_controller.sv
// Bench for game_turn_controller: instance a (3 players, STEP_PERIOD=4) runs
// a cycle-by-cycle vector table with a step_pulse timing scoreboard; instance b
// (2 players, TRACK_LEN=4, TIMEOUT_CYCLES=10) covers goal, disable and timeout.
module tb_game_turn_controller;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_MOVE = 3'd2;
  localparam logic [2:0] S_WC   = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_WIN  = 3'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        en [2];
  logic        rr [2];
  logic [1:0]  ms [2];
  logic        te [2];
  logic [1:0]  cp [2];
  logic [19:0] pp [2];
  logic        sp [2];
  logic [2:0]  st [2];
  logic        go [2];
  logic [1:0]  win[2];
  logic        ts [2];

  game_turn_controller #(
    .NUM_PLAYERS(3), .TRACK_LEN(20), .STEP_PERIOD(4), .TIMEOUT_CYCLES(1000)
  ) dut_a (
    .clk(clk), .reset(reset), .game_enable(en[0]), .result_ready(rr[0]),
    .movement_steps(ms[0]), .turn_end(te[0]), .current_player(cp[0]), .player_pos(pp[0]),
    .step_pulse(sp[0]), .state_out(st[0]), .game_over(go[0]), .winner(win[0]),
    .turn_skipped(ts[0])
  );

  game_turn_controller #(
    .NUM_PLAYERS(2), .TRACK_LEN(4), .STEP_PERIOD(4), .TIMEOUT_CYCLES(10)
  ) dut_b (
    .clk(clk), .reset(reset), .game_enable(en[1]), .result_ready(rr[1]),
    .movement_steps(ms[1]), .turn_end(te[1]), .current_player(cp[1]), .player_pos(pp[1]),
    .step_pulse(sp[1]), .state_out(st[1]), .game_over(go[1]), .winner(win[1]),
    .turn_skipped(ts[1])
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_q[$];
  int mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every step_pulse on instance a must match the next expected cycle.
  always @(negedge clk) begin
    if (sp[0] === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL step_pulse_unexpected: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("step_pulse_time", cyc, mon_e);
      end
    end
  end

  typedef struct {
    logic        en;
    logic        rr;
    logic [1:0]  ms;
    logic        te;
    int          push;
    logic [2:0]  st;
    logic [1:0]  pl;
    logic [19:0] pos;
    logic        sp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] mkpos(input int p0, input int p1, input int p2);
    return {5'd0, 5'(p2), 5'(p1), 5'(p0)};
  endfunction

  task automatic add(input logic e, input logic r, input logic [1:0] m, input logic t,
                     input int pu, input logic [2:0] s, input logic [1:0] p,
                     input logic [19:0] po, input logic spx);
    vecs.push_back('{e, r, m, t, pu, s, p, po, spx});
  endtask

  task automatic addn(input int n, input logic [2:0] s, input logic [1:0] p,
                      input logic [19:0] po);
    repeat (n) add(1, 0, 2'd0, 0, 0, s, p, po, 0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  int cnt;
  int skip_at;
  int skip_cnt;
  logic [2:0] st_after;
  logic [1:0] cp_after;
  logic [19:0] pp_after;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      en[d] = 0; rr[d] = 0; ms[d] = 2'd0; te[d] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_state", {29'd0, st[0]}, 32'(S_IDLE));
    chk("reset_pos", {12'd0, pp[0]}, 32'd0);
    chk("reset_outs", {28'd0, sp[0], go[0], win[0]}, 32'd0);
    chk("reset_skip", {31'd0, ts[1]}, 32'd0);
    reset = 1'b0;

    // ---- vector table on instance a ----
    add(0, 0, 2'd0, 0, 0, S_IDLE, 0, 0, 0);
    add(1, 0, 2'd0, 0, 0, S_WR, 0, 0, 0);
    add(1, 1, 2'd0, 0, 0, S_WR, 0, 0, 0);              // zero roll ignored
    add(1, 0, 2'd0, 1, 0, S_WR, 0, 0, 0);              // stray turn_end dropped
    add(1, 1, 2'd2, 0, 2, S_MOVE, 0, 0, 0);
    add(1, 0, 2'd0, 1, 0, S_MOVE, 0, 0, 0);            // turn_end during MOVE
    addn(2, S_MOVE, 0, 0);
    add(1, 0, 2'd0, 0, 0, S_MOVE, 0, mkpos(1, 0, 0), 1);
    addn(3, S_MOVE, 0, mkpos(1, 0, 0));
    add(1, 0, 2'd0, 0, 0, S_WC, 0, mkpos(2, 0, 0), 1);
    add(1, 0, 2'd0, 1, 0, S_NEXT, 0, mkpos(2, 0, 0), 0);
    add(1, 0, 2'd0, 0, 0, S_WR, 1, mkpos(2, 0, 0), 0);
    add(1, 1, 2'd1, 0, 1, S_MOVE, 1, mkpos(2, 0, 0), 0);
    addn(3, S_MOVE, 1, mkpos(2, 0, 0));
    add(1, 0, 2'd0, 0, 0, S_WC, 1, mkpos(2, 1, 0), 1);
    add(1, 0, 2'd0, 1, 0, S_NEXT, 1, mkpos(2, 1, 0), 0);
    add(1, 0, 2'd0, 0, 0, S_WR, 2, mkpos(2, 1, 0), 0);
    add(1, 1, 2'd3, 0, 3, S_MOVE, 2, mkpos(2, 1, 0), 0);
    addn(3, S_MOVE, 2, mkpos(2, 1, 0));
    add(1, 0, 2'd0, 0, 0, S_MOVE, 2, mkpos(2, 1, 1), 1);
    addn(3, S_MOVE, 2, mkpos(2, 1, 1));
    add(1, 0, 2'd0, 0, 0, S_MOVE, 2, mkpos(2, 1, 2), 1);
    addn(3, S_MOVE, 2, mkpos(2, 1, 2));
    add(1, 0, 2'd0, 0, 0, S_WC, 2, mkpos(2, 1, 3), 1);
    add(1, 0, 2'd0, 1, 0, S_NEXT, 2, mkpos(2, 1, 3), 0);
    add(1, 0, 2'd0, 0, 0, S_WR, 0, mkpos(2, 1, 3), 0);  // wrap to player 0
    add(1, 1, 2'd2, 0, 2, S_MOVE, 0, mkpos(2, 1, 3), 0);
    add(1, 0, 2'd0, 1, 0, S_MOVE, 0, mkpos(2, 1, 3), 0);
    repeat (7) add(0, 0, 2'd0, 0, 0, S_IDLE, 0, 0, 0);  // disable mid-MOVE

    for (int i = 0; i < vecs.size(); i++) begin
      en[0] = vecs[i].en;
      rr[0] = vecs[i].rr;
      ms[0] = vecs[i].ms;
      te[0] = vecs[i].te;
      if (!vecs[i].en) exp_q.delete();
      for (int k = 1; k <= vecs[i].push; k++) exp_q.push_back(cyc + 1 + 4 * k);
      tick();
      chk($sformatf("v%0d_state", i), {29'd0, st[0]}, {29'd0, vecs[i].st});
      chk($sformatf("v%0d_player", i), {30'd0, cp[0]}, {30'd0, vecs[i].pl});
      chk($sformatf("v%0d_pos", i), {12'd0, pp[0]}, {12'd0, vecs[i].pos});
      chk($sformatf("v%0d_step", i), {31'd0, sp[0]}, {31'd0, vecs[i].sp});
    end
    rr[0] = 0; te[0] = 0;
    chk("sb_drained", exp_q.size(), 0);

    // ---- goal on instance b (TRACK_LEN=4) ----
    en[1] = 1; tick();
    chk("b_wr", {29'd0, st[1]}, 32'(S_WR));
    rr[1] = 1; ms[1] = 2'd2; tick(); rr[1] = 0;
    chk("b_move", {29'd0, st[1]}, 32'(S_MOVE));
    cnt = 0;
    repeat (8) begin tick(); if (sp[1]) cnt++; end
    chk("b_p0_pulses", cnt, 2);
    chk("b_p0_pos", {12'd0, pp[1]}, 32'h2);
    chk("b_p0_wc", {29'd0, st[1]}, 32'(S_WC));
    te[1] = 1; tick(); te[1] = 0;
    chk("b_next", {29'd0, st[1]}, 32'(S_NEXT));
    tick();
    chk("b_p1_turn", {30'd0, cp[1]}, 32'd1);
    rr[1] = 1; ms[1] = 2'd1; tick(); rr[1] = 0;
    repeat (4) tick();
    chk("b_p1_pos", {12'd0, pp[1]}, 32'h22);
    te[1] = 1; tick(); te[1] = 0; tick();
    chk("b_p0_again", {29'd0, st[1], cp[1]}, {27'd0, S_WR, 2'd0});
    rr[1] = 1; ms[1] = 2'd3; tick(); rr[1] = 0;
    cnt = 0;
    repeat (14) begin tick(); if (sp[1]) cnt++; end
    chk("b_goal_pulses", cnt, 1);
    chk("b_goal_pos", {12'd0, pp[1]}, 32'h23);
    chk("b_goal_state", {29'd0, st[1]}, 32'(S_WIN));
    chk("b_game_over", {31'd0, go[1]}, 32'd1);
    chk("b_winner", {30'd0, win[1]}, 32'd0);
    en[1] = 0; tick();
    chk("b_disable", {11'd0, st[1], go[1], pp[1]}, 32'd0);

    // ---- roll timeout on instance b ----
    en[1] = 1; tick();
    skip_at = -1; skip_cnt = 0;
    st_after = 3'd7; cp_after = 2'd3; pp_after = '1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (ts[1]) begin
        skip_cnt++;
        if (skip_at < 0) skip_at = j;
      end
      if (j == 11) begin st_after = st[1]; cp_after = cp[1]; pp_after = pp[1]; end
    end
`ifdef TURN_TIMEOUT_EN
    chk("to_skip_at", skip_at, 10);
    chk("to_skip_cnt", skip_cnt, 1);
    chk("to_state", {29'd0, st_after}, 32'(S_WR));
    chk("to_player", {30'd0, cp_after}, 32'd1);
`else
    chk("to_skip_at", skip_at, -1);
    chk("to_skip_cnt", skip_cnt, 0);
    chk("to_state", {29'd0, st_after}, 32'(S_WR));
    chk("to_player", {30'd0, cp_after}, 32'd0);
`endif
    chk("to_pos", {12'd0, pp_after}, 32'd0);
    en[1] = 0;

    // ---- reset during MOVE on instance a ----
    en[0] = 1; tick();
    rr[0] = 1; ms[0] = 2'd3; tick(); rr[0] = 0;
    chk("rst_pre_move", {29'd0, st[0]}, 32'(S_MOVE));
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_async_state", {29'd0, st[0]}, 32'(S_IDLE));
    chk("rst_async_outs", {12'd0, pp[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) tick();
    chk("rst_after_state", {29'd0, st[0]}, 32'(S_WR));
    chk("rst_after_pos", {12'd0, pp[0]}, 32'd0);
    chk("rst_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/game_turn_controller.md
GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

Interface
REQ-001 Parameter NUM_PLAYERS, default 2: active players, legal range 2..4.
REQ-002 Parameter TRACK_LEN, default 20: track squares, legal range 4..32; the goal square is TRACK_LEN-1.
REQ-003 Parameter STEP_PERIOD, default 25_000_000: clk cycles between successive step pulses, must be at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 250_000_000: cycles allowed in WAIT_ROLL before the turn is skipped.
REQ-005 Port clk, input, 1 bit: single system clock (sys_clk domain); the block SHALL use one clock only.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port game_enable, input, 1 bit: level; driven by the color-detection mode switch.
REQ-008 Port result_ready, input, 1 bit: one-cycle pulse marking a new stable die result.
REQ-009 Port movement_steps, input, 2 bits: step count qualified by result_ready.
REQ-010 Port turn_end, input, 1 bit: one-cycle pulse marking that the die has been cleared from the ROI.
REQ-011 Port current_player, output, 2 bits: index of the player whose turn it is.
REQ-012 Port player_pos, output, 20 bits: 5 bits per player; player i occupies bits [5i+4:5i]; unused slots read 0.
REQ-013 Port step_pulse, output, 1 bit: one cycle per square advanced.
REQ-014 Port state_out, output, 3 bits: encoding of the current FSM state.
REQ-015 Port game_over, output, 1 bit: level, high while in the WIN state.
REQ-016 Port winner, output, 2 bits: winning player index, valid while game_over is high.
REQ-017 Port turn_skipped, output, 1 bit: one-cycle pulse on turn timeout.

Function
REQ-018 The FSM SHALL have six states: IDLE=0, WAIT_ROLL=1, MOVE=2, WAIT_CLEAR=3, NEXT=4, WIN=5.
REQ-019 From IDLE, game_enable high SHALL cause a transition to WAIT_ROLL with current_player=0 and all positions set to 0.
REQ-020 In WAIT_ROLL, result_ready high with movement_steps nonzero SHALL latch steps_left=movement_steps and transition to MOVE on the next cycle.
REQ-021 In WAIT_ROLL, result_ready high with movement_steps=0 SHALL be ignored.
REQ-022 In MOVE, the step timer SHALL reload to STEP_PERIOD-1 on entry and count down to 0.
REQ-023 In MOVE, each time the step timer reaches 0 the block SHALL assert step_pulse for one cycle, increment the current player's position, decrement steps_left, and reload the timer.
REQ-024 The first step_pulse SHALL occur exactly STEP_PERIOD cycles after the cycle in which result_ready is sampled high; subsequent pulses SHALL be spaced STEP_PERIOD cycles apart.
REQ-025 Position SHALL saturate at TRACK_LEN-1: reaching the goal ends MOVE immediately, any remaining steps are discarded, and the FSM enters WIN.
REQ-026 When steps_left reaches 0 without reaching the goal, the FSM SHALL enter WAIT_CLEAR.
REQ-027 In WAIT_CLEAR, a turn_end pulse SHALL cause a transition to NEXT.
REQ-028 NEXT SHALL last one cycle: current_player advances modulo NUM_PLAYERS, and the FSM returns to WAIT_ROLL.
REQ-029 result_ready outside WAIT_ROLL and turn_end outside WAIT_CLEAR SHALL be dropped, not queued.
REQ-030 WIN SHALL hold game_over=1 and winner=current_player until game_enable falls.
REQ-031 game_enable low in any state SHALL force IDLE on the next cycle and clear all positions, timers and steps_left; this has priority over every other event in the same cycle.
REQ-032 step_pulse and turn_skipped SHALL be registered outputs; all other outputs SHALL be derived directly from state registers.

Reset
REQ-033 On reset assertion, asynchronously: state=IDLE, current_player=0, player_pos=0, step_pulse=0, game_over=0, winner=0, turn_skipped=0, and all counters=0.
REQ-034 Reset asserted mid-MOVE SHALL abort the move; no partial-step pulse SHALL follow reset release.

Configuration
REQ-035 With TURN_TIMEOUT_EN defined, WAIT_ROLL SHALL count cycles; at TIMEOUT_CYCLES with no accepted result, the block SHALL pulse turn_skipped and go to NEXT without moving. The counter clears on every entry to WAIT_ROLL.
REQ-036 Without TURN_TIMEOUT_EN, no timeout counter SHALL be synthesized, turn_skipped SHALL be tied to 0, and WAIT_ROLL SHALL wait indefinitely.

Structure
REQ-037 The package dice_race_pkg SHALL hold the state enum, the color codes (NONE=0, RED=1, GREEN=2, BLUE=3), MAX_PLAYERS=4, and POS_W=5.
REQ-038 The step timer SHALL be a sub-module, step_timer, with load, enable and tick signals; the FSM and position registers SHALL live in the top module.

Verification
REQ-039 Run with STEP_PERIOD=4: enable, then result_ready with steps=3 at cycle N -> step_pulse at N+4, N+8 and N+12; player0 position 3; state WAIT_CLEAR.
REQ-040 Then turn_end -> one cycle in NEXT, current_player=1, state WAIT_ROLL; a turn_end pulse sent during MOVE leaves the FSM unchanged.
REQ-041 Run with TRACK_LEN=4, player at position 2, steps=3 -> exactly one step_pulse, position 3, game_over=1, winner=0.
REQ-042 Drop game_enable mid-MOVE -> IDLE on the next cycle, player_pos=0, no further step_pulse.
REQ-043 Run with TURN_TIMEOUT_EN defined and TIMEOUT_CYCLES=10, no result -> turn_skipped pulse after 10 cycles in WAIT_ROLL, player advanced, position unchanged; with the macro undefined -> the FSM stays in WAIT_ROLL.
REQ-044 Run with NUM_PLAYERS=3, three full turns -> current_player sequence 0, 1, 2, 0; player_pos bits [19:15] remain 0 throughout.
